writeback_rf: RTL and testbench
===============================

WRITEBACK_RF -- requirements
Module: writeback_rf

Interface
REQ-001 Parameters: none; widths come from the shared package (DATA_W=32, REG_ADDR_W=5, NUM_REGS=32).
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_valid  input  1  MEM-stage result offered this cycle.
REQ-005 wb_reg_write  input  1  instruction writes a GPR.
REQ-006 wb_mem_to_reg  input  1  1 = write wb_mem_data, 0 = write wb_alu_result.
REQ-007 wb_dst  input  5  destination GPR (rd or rt, already selected upstream).
REQ-008 wb_alu_result  input  32  ALU result.
REQ-009 wb_mem_data  input  32  load data.
REQ-010 wb_stall  input  1  hold MEM/WB register, suppress write.
REQ-011 rs_addr, rt_addr  input  5 each  decode-stage read addresses.
REQ-012 rs_data, rt_data  output  32 each  decode-stage read data.
REQ-013 commit_valid  output  1  a GPR write commits at the next rising edge.
REQ-014 commit_dst  output  5  GPR being written.
REQ-015 commit_data  output  32  value being written.

Function
REQ-016 MEM/WB register (pipe_valid, pipe_reg_write, pipe_dst, pipe_data) SHALL load at each edge with wb_stall=0; pipe_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result, muxed before capture.
REQ-017 With wb_stall=1 the MEM/WB register SHALL hold its contents and the wb_* inputs SHALL be ignored.
REQ-018 Write enable we = pipe_valid & pipe_reg_write & (pipe_dst != 0) & ~wb_stall; at an edge with we=1, GPR[pipe_dst] SHALL take pipe_data.
REQ-019 Each captured entry SHALL be written exactly once: a held entry SHALL write at the first edge with wb_stall=0.
REQ-020 commit_valid = we; commit_dst = pipe_dst; commit_data = pipe_data (combinational from the MEM/WB register).
REQ-021 Reads SHALL be combinational; address 0 SHALL return 0 whatever was written.
REQ-022 Bypass: if pipe_valid & pipe_reg_write & pipe_dst != 0 and pipe_dst equals a read address, that port SHALL return pipe_data (stalled or not).
REQ-023 Latency: a result offered at edge N SHALL be readable via bypass in cycle N..N+1 and from the array after edge N+1.
REQ-024 rs_addr == rt_addr SHALL return identical data on both ports, bypass included.
REQ-025 wb_dst=0 with wb_reg_write=1 SHALL change nothing and SHALL NOT assert commit_valid.
REQ-026 wb_valid=0 SHALL clear pipe_valid at the capture edge; pipe_reg_write, pipe_dst and pipe_data are then don't-care.

Reset
REQ-027 At an edge with rst=1: pipe_valid=0, pipe_reg_write=0, pipe_dst=0, pipe_data=0.
REQ-028 At an edge with rst=1: GPR[i] SHALL load i for i=1..31, the bring-up preload.
REQ-029 rst SHALL take priority over wb_stall and over a pending write; a held entry is dropped.
REQ-030 In the cycle after reset, commit_valid=0 and rs_data/rt_data SHALL show the preload values.

Structure
REQ-031 Package mips_pkg SHALL hold DATA_W, REG_ADDR_W, NUM_REGS, REG_ZERO=5'd0, and the typedefs reg_addr_t and word_t.
REQ-032 The storage array SHALL be a sub-module named mips_gpr_array, with 1 write port, 2 async read ports, preload-on-rst and the r0 rule.
REQ-033 writeback_rf SHALL contain only the MEM/WB register, the data mux, write-enable logic and the bypass.

Verification
REQ-034 Reset, then read rs=5, rt=31 -> 5 and 31; read rs=0 -> 0.
REQ-035 Offer wb_dst=7, alu=0xDEADBEEF, mem_to_reg=0 at edge N; read rs=7 in cycle N+1 -> 0xDEADBEEF via bypass; commit_valid=1 for one cycle; read again after N+2 -> 0xDEADBEEF from the array.
REQ-036 Offer a load with wb_dst=3, mem=0x12345678, alu=0xFFFFFFFF, mem_to_reg=1; hold wb_stall=1 for 3 cycles -> commit_valid=0 and rt=3 reads 0x12345678 throughout; release -> exactly one commit.
REQ-037 Offer wb_dst=0, alu=0xAAAA5555 -> commit_valid=0; rs=0 reads 0.
REQ-038 Back-to-back writes to reg 9 (0x1, then 0x2) with rs=rt=9 -> 0x1 then 0x2 on both ports, no stale cycle.
REQ-039 Assert rst while an entry for reg 4 is held under stall -> no write; reg 4 reads 4 after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, typedefs and MEM/WB register layout for the MIPS writeback slice.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      valid;
    logic      reg_write;
    reg_addr_t dst;
    word_t     data;
  } mem_wb_t;

  function automatic word_t select_wb_data(input logic mem_to_reg,
                                           input word_t mem_data,
                                           input word_t alu_result);
    return mem_to_reg ? mem_data : alu_result;
  endfunction

endpackage

// File: rtl/mips_gpr_array.sv
// 32-entry GPR storage: one synchronous write port, two asynchronous read ports,
// r0 hardwired to zero, and an identity preload (GPR[i] = i) on reset.
module mips_gpr_array
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  reg_addr_t raddr_a_i,
  input  reg_addr_t raddr_b_i,
  output word_t     rdata_a_o,
  output word_t     rdata_b_o
);

  word_t regs_q [NUM_REGS];

  // Reset wins over any write in the same cycle; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= word_t'(i);
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/writeback_rf.sv
// Writeback stage: MEM/WB register, result mux, GPR write enable and
// same-cycle bypass of the pending writeback onto both decode read ports.
module writeback_rf
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_valid,
  input  logic      wb_reg_write,
  input  logic      wb_mem_to_reg,
  input  reg_addr_t wb_dst,
  input  word_t     wb_alu_result,
  input  word_t     wb_mem_data,
  input  logic      wb_stall,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output word_t     rs_data,
  output word_t     rt_data,
  output logic      commit_valid,
  output reg_addr_t commit_dst,
  output word_t     commit_data
);

  mem_wb_t pipe_q, pipe_d;
  logic    pipe_live;
  logic    we;
  word_t   arr_rs_data, arr_rt_data;

  // A stalled register keeps its entry so it commits exactly once on release.
  always_comb begin
    pipe_d = pipe_q;
    if (!wb_stall) begin
      pipe_d.valid     = wb_valid;
      pipe_d.reg_write = wb_reg_write;
      pipe_d.dst       = wb_dst;
      pipe_d.data      = select_wb_data(wb_mem_to_reg, wb_mem_data, wb_alu_result);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pipe_live = pipe_q.valid && pipe_q.reg_write && (pipe_q.dst != REG_ZERO);
  assign we        = pipe_live && !wb_stall;

  assign commit_valid = we;
  assign commit_dst   = pipe_q.dst;
  assign commit_data  = pipe_q.data;

  mips_gpr_array u_gpr (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .waddr_i   (pipe_q.dst),
    .wdata_i   (pipe_q.data),
    .raddr_a_i (rs_addr),
    .raddr_b_i (rt_addr),
    .rdata_a_o (arr_rs_data),
    .rdata_b_o (arr_rt_data)
  );

  // Bypass applies even while stalled, since the array has not seen the value yet.
  assign rs_data = (pipe_live && (pipe_q.dst == rs_addr)) ? pipe_q.data : arr_rs_data;
  assign rt_data = (pipe_live && (pipe_q.dst == rt_addr)) ? pipe_q.data : arr_rt_data;

endmodule

// File: tb/tb_writeback_rf.sv
// Self-checking bench for writeback_rf: architectural model plus directed literal checks.
module tb_writeback_rf;
  import mips_pkg::*;

  logic      clk;
  logic      rst;
  logic      wb_valid, wb_reg_write, wb_mem_to_reg, wb_stall;
  reg_addr_t wb_dst, rs_addr, rt_addr;
  word_t     wb_alu_result, wb_mem_data;
  word_t     rs_data, rt_data, commit_data;
  logic      commit_valid;
  reg_addr_t commit_dst;

  int vectors = 0;
  int miscompares = 0;

  writeback_rf dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dst        (wb_dst),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .wb_stall      (wb_stall),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .commit_valid  (commit_valid),
    .commit_dst    (commit_dst),
    .commit_data   (commit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: committed register values plus at most one accepted,
  // not-yet-committed result that is visible to readers immediately.
  word_t     modelRegs [32];
  bit        modelReady = 1'b0;
  bit        pendValid  = 1'b0;
  reg_addr_t pendDst;
  word_t     pendData;

  function automatic word_t expRead(input reg_addr_t addr);
    if (addr == 5'd0) return 32'd0;
    if (pendValid && pendDst == addr) return pendData;
    return modelRegs[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'(i);
      pendValid  = 1'b0;
      modelReady = 1'b1;
    end else if (!wb_stall) begin
      if (pendValid) modelRegs[pendDst] = pendData;
      pendValid = wb_valid && wb_reg_write && (wb_dst != 5'd0);
      pendDst   = wb_dst;
      pendData  = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    end
  end

  // Every cycle after the first reset edge, outputs must match the model.
  always @(negedge clk) begin
    if (modelReady) begin
      logic expCommit;
      expCommit = pendValid && !wb_stall;
      checkOutput("commit_valid", 32'(commit_valid), 32'(expCommit));
      if (expCommit) begin
        checkOutput("commit_dst", 32'(commit_dst), 32'(pendDst));
        checkOutput("commit_data", commit_data, pendData);
      end
      checkOutput("rs_data", rs_data, expRead(rs_addr));
      checkOutput("rt_data", rt_data, expRead(rt_addr));
    end
  end

  task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                               input reg_addr_t dst, input word_t alu, input word_t mem,
                               input logic stall, input reg_addr_t rsA, input reg_addr_t rtA);
    wb_valid      = v;
    wb_reg_write  = rw;
    wb_mem_to_reg = m2r;
    wb_dst        = dst;
    wb_alu_result = alu;
    wb_mem_data   = mem;
    wb_stall      = stall;
    rs_addr       = rsA;
    rt_addr       = rtA;
    @(negedge clk);
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0; wb_stall = 0;
    wb_dst = 0; wb_alu_result = 0; wb_mem_data = 0; rs_addr = 0; rt_addr = 0;
    nextEdge();
    nextEdge();
    rst = 1'b0;

    // Preload visible right after reset, r0 reads zero.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd31);
    checkOutput("lit_preload_rs5", rs_data, 32'd5);
    checkOutput("lit_preload_rt31", rt_data, 32'd31);
    checkOutput("lit_commit_after_rst", 32'(commit_valid), 32'd0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("lit_r0_read", rs_data, 32'd0);
    nextEdge();

    // ALU write to r7: bypass, single commit, then array.
    applyStimulus(1, 1, 0, 5'd7, 32'hDEADBEEF, 32'h0, 0, 5'd7, 5'd0);
    checkOutput("lit_r7_before", rs_data, 32'd7);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd7, 5'd7);
    checkOutput("lit_r7_bypass", rs_data, 32'hDEADBEEF);
    checkOutput("lit_r7_commit", 32'(commit_valid), 32'd1);
    checkOutput("lit_r7_commit_dst", 32'(commit_dst), 32'd7);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd7, 5'd0);
    checkOutput("lit_r7_array", rs_data, 32'hDEADBEEF);
    checkOutput("lit_r7_commit_once", 32'(commit_valid), 32'd0);
    nextEdge();

    // Load to r3 held by three stall cycles while the inputs carry junk.
    applyStimulus(1, 1, 1, 5'd3, 32'hFFFFFFFF, 32'h12345678, 0, 5'd0, 5'd3);
    nextEdge();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 5'd3, 32'h0BAD0BAD, 32'h0, 1, 5'd0, 5'd3);
      checkOutput("lit_r3_stall_commit", 32'(commit_valid), 32'd0);
      checkOutput("lit_r3_stall_bypass", rt_data, 32'h12345678);
      nextEdge();
    end
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd3);
    checkOutput("lit_r3_release_commit", 32'(commit_valid), 32'd1);
    checkOutput("lit_r3_release_data", commit_data, 32'h12345678);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd3);
    checkOutput("lit_r3_single_commit", 32'(commit_valid), 32'd0);
    checkOutput("lit_r3_array", rt_data, 32'h12345678);
    nextEdge();

    // Write to r0 is discarded; invalid offer with reg_write is discarded too.
    applyStimulus(1, 1, 0, 5'd0, 32'hAAAA5555, 32'h0, 0, 5'd0, 5'd0);
    nextEdge();
    applyStimulus(0, 1, 0, 5'd5, 32'h55555555, 32'h0, 0, 5'd0, 5'd5);
    checkOutput("lit_r0_no_commit", 32'(commit_valid), 32'd0);
    checkOutput("lit_r0_still_zero", rs_data, 32'd0);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd5);
    checkOutput("lit_invalid_no_commit", 32'(commit_valid), 32'd0);
    checkOutput("lit_r5_unchanged", rt_data, 32'd5);
    nextEdge();

    // Back-to-back writes to r9 observed on both ports.
    applyStimulus(1, 1, 0, 5'd9, 32'h1, 32'h0, 0, 5'd9, 5'd9);
    nextEdge();
    applyStimulus(1, 1, 0, 5'd9, 32'h2, 32'h0, 0, 5'd9, 5'd9);
    checkOutput("lit_r9_first_rs", rs_data, 32'h1);
    checkOutput("lit_r9_first_rt", rt_data, 32'h1);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd9, 5'd9);
    checkOutput("lit_r9_second_rs", rs_data, 32'h2);
    checkOutput("lit_r9_second_rt", rt_data, 32'h2);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd9, 5'd9);
    checkOutput("lit_r9_array", rt_data, 32'h2);
    nextEdge();

    // Reset while r4's entry is held: the entry is dropped.
    applyStimulus(1, 1, 0, 5'd4, 32'h44444444, 32'h0, 0, 5'd4, 5'd7);
    nextEdge();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd4, 5'd7);
    checkOutput("lit_r4_held_bypass", rs_data, 32'h44444444);
    nextEdge();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd4, 5'd7);
    nextEdge();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd4, 5'd7);
    checkOutput("lit_r4_after_rst", rs_data, 32'd4);
    checkOutput("lit_r7_after_rst", rt_data, 32'd7);
    checkOutput("lit_r4_no_commit", 32'(commit_valid), 32'd0);
    nextEdge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
